clause_loader: RTL and testbench
================================

# clause_loader

Upstream feeder for the SAT solver core `top`. It accepts one clause per handshake beat as a positive/negative literal mask pair and buffers a whole problem in an internal FIFO. When the producer marks the last clause, it replays the buffer to the solver as one contiguous `load` burst on `i`: the positive word, then the negative word, for each clause. Tautological clauses are dropped and capacity overflow is flagged, so the solver only receives well-formed problems.

## Interface
- `NUM_LIT`, default `common::number_literal`: literal count; width of every mask and of `i`.
- `MAX_CLAUSES`, default 8: FIFO depth in clauses (≥2).
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low; clears the FIFO, counters, flags and outputs.
- `in_valid`  in  1  a clause is presented.
- `in_ready`  out  1  the loader accepts the clause this cycle.
- `in_pos`  in  NUM_LIT  positive-literal mask; bit n set means literal n appears uncomplemented.
- `in_neg`  in  NUM_LIT  negative-literal mask; bit n set means literal n appears complemented.
- `in_last`  in  1  the presented clause is the final one of the problem.
- `load`  out  1  drives the solver `load` input.
- `i`  out  NUM_LIT  drives the solver `i` input.
- `done`  out  1  one-cycle pulse when a burst completes.
- `overflow`  out  1  valid with `done`: clauses beyond MAX_CLAUSES were discarded.
- `empty_prob`  out  1  valid with `done`: zero clauses were stored.
- `dropped`  out  $clog2(MAX_CLAUSES+1)  count of tautologies dropped; saturates.

## Operation
- States: FILL, POS, NEG, FIN.
- FILL:
  - `in_ready` = 1; a beat is accepted when `in_valid & in_ready`.
  - If `(in_pos & in_neg) != 0`, the clause is a tautology: it is not stored, and `dropped` increments (saturating).
  - Otherwise, if count < MAX_CLAUSES, the clause is pushed.
  - Otherwise the clause is discarded and `overflow` is set. The flag is sticky until the loader returns to FILL.
  - An empty clause (both masks 0) is stored and forwarded unchanged.
  - Accepting a beat with `in_last` = 1 moves to POS if count > 0 after this beat, else to FIN.
- POS: `load` = 1, `i` = pos word of the head entry. Next state is NEG.
- NEG:
  - `load` = 1, `i` = neg word of the head entry; the head is popped.
  - If entries remain, next state is POS; else FIN.
- FIN: `load` = 0, `i` = 0, `done` = 1 for exactly one cycle. The next state is FILL, where count, `overflow`, `empty_prob` and `dropped` are cleared.
- In POS, NEG and FIN, `in_ready` = 0 and inputs are ignored.
- `load`, `i`, `done`, `overflow` and `empty_prob` are registered outputs. `in_ready` is a combinational decode of state only.

## Timing
- Reset values: state FILL, `in_ready` = 1, `load` = 0, `i` = 0, `done` = 0, `overflow` = 0, `empty_prob` = 0, `dropped` = 0, FIFO empty.
- Edge E0 accepts the last clause.
- From E1, `load` = 1 and `i` = pos0; from E2, `i` = neg0; and so on through E(2N), `i` = neg(N-1).
- From E(2N+1): `load` = 0, `i` = 0, `done` = 1.
- From E(2N+2): `done` = 0 and `in_ready` = 1.
- `load` never deasserts mid-burst.
- Zero stored clauses: `load` never rises. `done` and `empty_prob` are 1 from E1; `in_ready` returns from E2.
- A full FIFO does not stall the producer, because discards are accepted (`in_ready` stays 1).
- A tautology carrying `in_last` still terminates the fill.
- Reset asserted mid-burst: `load` and `i` go to 0 immediately (asynchronously), and the partial problem is lost.
- Back-to-back problems are supported. The next fill may begin the cycle `in_ready` returns; no extra idle cycle is required.

## Test plan
- NUM_LIT = 3. Clauses (110,000), (101,000), (010,101), (000,011), (011,100+last) -> `load` high for exactly 10 cycles starting the cycle after last. `i` = 110, 000, 101, 000, 010, 101, 000, 011, 011, 100. Then `done` = 1, `overflow` = 0, `dropped` = 0.
- Clauses (110,010), (001,000+last) -> the first is a tautology and is dropped. Burst is 001, 000 (2 cycles); `dropped` = 1 with `done`.
- MAX_CLAUSES = 8; 10 distinct non-tautological clauses, last on the 10th -> 16-cycle burst of the first 8 clauses in order; `overflow` = 1 with `done`.
- Single beat (011,011+last) -> no `load`; `done` = 1 and `empty_prob` = 1 on the next cycle; `in_ready` = 1 one cycle later.
- Reset pulsed low during the 3rd burst word of the first scenario -> `load` = 0 and `i` = 0 immediately, `in_ready` = 1. Reloading the same problem reproduces the full 10-word sequence.
- Two problems back-to-back, with the second `in_valid` asserted continuously -> `in_ready` is low throughout burst 1 and FIN. The second problem is accepted from the first FILL cycle, and its burst contains no words from problem 1.

Source files
------------

// File: rtl/common.sv
// Shared solver-wide constants.
package common;
    parameter int number_literal = 3;
endpackage

// File: rtl/clause_loader.sv
// clause_loader: buffers one SAT problem (pos/neg literal masks per clause),
// drops tautologies, flags capacity overflow, then replays the stored clauses
// to the solver as a single contiguous load burst (pos word, neg word, ...).
module clause_loader #(
    parameter int NUM_LIT     = common::number_literal,
    parameter int MAX_CLAUSES = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NUM_LIT-1:0]                 in_pos,
    input  logic [NUM_LIT-1:0]                 in_neg,
    input  logic                               in_last,
    output logic                               load,
    output logic [NUM_LIT-1:0]                 i,
    output logic                               done,
    output logic                               overflow,
    output logic                               empty_prob,
    output logic [$clog2(MAX_CLAUSES+1)-1:0]   dropped
);

    localparam int CW = $clog2(MAX_CLAUSES + 1);
    localparam int AW = $clog2(MAX_CLAUSES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_CLAUSES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] DROP_SAT = {CW{1'b1}};
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
    localparam logic [NUM_LIT-1:0] WORD_ZERO = {NUM_LIT{1'b0}};

    typedef enum logic [1:0] {
        FILL = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [CW-1:0]        count_r;
    logic [CW-1:0]        count_s;
    logic [AW-1:0]        rd_r;
    logic [AW-1:0]        rd_s;
    logic                 load_r;
    logic                 load_s;
    logic [NUM_LIT-1:0]   i_r;
    logic [NUM_LIT-1:0]   i_s;
    logic                 done_r;
    logic                 done_s;
    logic                 overflow_r;
    logic                 overflow_s;
    logic                 empty_prob_r;
    logic                 empty_prob_s;
    logic [CW-1:0]        dropped_r;
    logic [CW-1:0]        dropped_s;
    logic                 push_s;
    logic                 taut_s;

    // Clause storage; occupancy is tracked by count_r, so no reset is needed.
    logic [NUM_LIT-1:0]   pos_mem_r [MAX_CLAUSES];
    logic [NUM_LIT-1:0]   neg_mem_r [MAX_CLAUSES];

    // A literal appearing both plain and complemented makes the clause always true.
    assign taut_s = |(in_pos & in_neg);

    // Producer may only hand over clauses while filling.
    assign in_ready = (state_r == FILL);

    assign load       = load_r;
    assign i          = i_r;
    assign done       = done_r;
    assign overflow   = overflow_r;
    assign empty_prob = empty_prob_r;
    assign dropped    = dropped_r;

    // State and output register; async reset drops load/i immediately mid-burst.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= FILL;
            count_r      <= CNT_ZERO;
            rd_r         <= PTR_ZERO;
            load_r       <= 1'b0;
            i_r          <= WORD_ZERO;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
            empty_prob_r <= 1'b0;
            dropped_r    <= CNT_ZERO;
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            rd_r         <= rd_s;
            load_r       <= load_s;
            i_r          <= i_s;
            done_r       <= done_s;
            overflow_r   <= overflow_s;
            empty_prob_r <= empty_prob_s;
            dropped_r    <= dropped_s;
        end
    end

    // Clause write port: the next free slot is always indexed by the current count.
    always_ff @(posedge clock) begin
        if (push_s) begin
            pos_mem_r[count_r[AW-1:0]] <= in_pos;
            neg_mem_r[count_r[AW-1:0]] <= in_neg;
        end
    end

    // Next-state and next-output decode; outputs follow the state one cycle later.
    always_comb begin
        state_s      = state_r;
        count_s      = count_r;
        rd_s         = rd_r;
        load_s       = 1'b0;
        i_s          = WORD_ZERO;
        done_s       = 1'b0;
        overflow_s   = overflow_r;
        empty_prob_s = empty_prob_r;
        dropped_s    = dropped_r;
        push_s       = 1'b0;

        case (state_r)
            FILL: begin
                if (in_valid) begin
                    if (taut_s) begin
                        if (dropped_r != DROP_SAT) begin
                            dropped_s = dropped_r + CNT_ONE;
                        end else begin
                            dropped_s = dropped_r;
                        end
                    end else if (count_r < CNT_MAX) begin
                        push_s  = 1'b1;
                        count_s = count_r + CNT_ONE;
                    end else begin
                        // Full: accept and discard so the producer never stalls.
                        overflow_s = 1'b1;
                    end

                    if (in_last) begin
                        if (count_s != CNT_ZERO) begin
                            state_s = POS;
                        end else begin
                            state_s      = FIN;
                            empty_prob_s = 1'b1;
                        end
                    end else begin
                        state_s = FILL;
                    end
                end else begin
                    state_s = FILL;
                end
            end

            POS: begin
                load_s  = 1'b1;
                i_s     = pos_mem_r[rd_r];
                state_s = NEG;
            end

            NEG: begin
                load_s  = 1'b1;
                i_s     = neg_mem_r[rd_r];
                rd_s    = rd_r + PTR_ONE;
                count_s = count_r - CNT_ONE;
                if (count_r > CNT_ONE) begin
                    state_s = POS;
                end else begin
                    state_s = FIN;
                end
            end

            FIN: begin
                // Hold FIN until the registered done pulse has been shown once,
                // so per-problem flags stay valid alongside done.
                if (done_r) begin
                    state_s      = FILL;
                    count_s      = CNT_ZERO;
                    rd_s         = PTR_ZERO;
                    overflow_s   = 1'b0;
                    empty_prob_s = 1'b0;
                    dropped_s    = CNT_ZERO;
                end else begin
                    done_s  = 1'b1;
                    state_s = FIN;
                end
            end

            default: begin
                state_s = FILL;
            end
        endcase
    end

endmodule

// File: tb/tb_clause_loader.sv
// Directed, table-driven bench for clause_loader (NUM_LIT=3, MAX_CLAUSES=8).
module tb_clause_loader;

    localparam int NL = 3;
    localparam int MC = 8;
    localparam int DW = $clog2(MC + 1);

    logic           clock;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [NL-1:0]  in_pos;
    logic [NL-1:0]  in_neg;
    logic           in_last;
    logic           load;
    logic [NL-1:0]  i;
    logic           done;
    logic           overflow;
    logic           empty_prob;
    logic [DW-1:0]  dropped;

    int checks;
    int errors;

    typedef struct packed {
        logic [7:0]         nbeats;
        logic [11:0][2:0]   pos;
        logic [11:0][2:0]   neg;
        logic [7:0]         nwords;
        logic [15:0][2:0]   words;
        logic               ovf;
        logic               emp;
        logic [3:0]         drop;
    } scen_t;

    scen_t tbl [4];
    scen_t btb_a;
    scen_t btb_b;

    clause_loader #(.NUM_LIT(NL), .MAX_CLAUSES(MC)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pos     (in_pos),
        .in_neg     (in_neg),
        .in_last    (in_last),
        .load       (load),
        .i          (i),
        .done       (done),
        .overflow   (overflow),
        .empty_prob (empty_prob),
        .dropped    (dropped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present every beat of a problem, one per cycle, last beat flagged.
    task automatic feed(input scen_t s, input string tag);
        for (int b = 0; b < int'(s.nbeats); b++) begin
            chk($sformatf("%s_ready_beat%0d", tag, b), 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_pos   = s.pos[b];
            in_neg   = s.neg[b];
            in_last  = (b == int'(s.nbeats) - 1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_pos   = 3'b000;
        in_neg   = 3'b000;
    endtask

    // Starting just after the last-beat edge, check burst, done cycle and return to FILL.
    task automatic drain(input scen_t s, input string tag);
        chk($sformatf("%s_ready_e0", tag), 32'(in_ready), 32'd0);
        chk($sformatf("%s_load_e0", tag), 32'(load), 32'd0);
        for (int w = 0; w < int'(s.nwords); w++) begin
            tick();
            chk($sformatf("%s_load_w%0d", tag, w), 32'(load), 32'd1);
            chk($sformatf("%s_i_w%0d", tag, w), 32'(i), 32'(s.words[w]));
            chk($sformatf("%s_ready_w%0d", tag, w), 32'(in_ready), 32'd0);
        end
        tick();
        chk($sformatf("%s_fin_load", tag), 32'(load), 32'd0);
        chk($sformatf("%s_fin_i", tag), 32'(i), 32'd0);
        chk($sformatf("%s_fin_done", tag), 32'(done), 32'd1);
        chk($sformatf("%s_fin_ovf", tag), 32'(overflow), 32'(s.ovf));
        chk($sformatf("%s_fin_empty", tag), 32'(empty_prob), 32'(s.emp));
        chk($sformatf("%s_fin_drop", tag), 32'(dropped), 32'(s.drop));
        chk($sformatf("%s_fin_ready", tag), 32'(in_ready), 32'd0);
        tick();
        chk($sformatf("%s_post_done", tag), 32'(done), 32'd0);
        chk($sformatf("%s_post_ready", tag), 32'(in_ready), 32'd1);
        chk($sformatf("%s_post_ovf", tag), 32'(overflow), 32'd0);
        chk($sformatf("%s_post_drop", tag), 32'(dropped), 32'd0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_pos   = 3'b000;
        in_neg   = 3'b000;
        in_last  = 1'b0;

        // Scenario 0: five plain clauses, 10-word burst.
        tbl[0] = '0;
        tbl[0].nbeats = 8'd5;
        tbl[0].pos[0] = 3'b110; tbl[0].neg[0] = 3'b000;
        tbl[0].pos[1] = 3'b101; tbl[0].neg[1] = 3'b000;
        tbl[0].pos[2] = 3'b010; tbl[0].neg[2] = 3'b101;
        tbl[0].pos[3] = 3'b000; tbl[0].neg[3] = 3'b011;
        tbl[0].pos[4] = 3'b011; tbl[0].neg[4] = 3'b100;
        tbl[0].nwords = 8'd10;
        tbl[0].words[0] = 3'b110; tbl[0].words[1] = 3'b000;
        tbl[0].words[2] = 3'b101; tbl[0].words[3] = 3'b000;
        tbl[0].words[4] = 3'b010; tbl[0].words[5] = 3'b101;
        tbl[0].words[6] = 3'b000; tbl[0].words[7] = 3'b011;
        tbl[0].words[8] = 3'b011; tbl[0].words[9] = 3'b100;

        // Scenario 1: leading tautology dropped.
        tbl[1] = '0;
        tbl[1].nbeats = 8'd2;
        tbl[1].pos[0] = 3'b110; tbl[1].neg[0] = 3'b010;
        tbl[1].pos[1] = 3'b001; tbl[1].neg[1] = 3'b000;
        tbl[1].nwords = 8'd2;
        tbl[1].words[0] = 3'b001; tbl[1].words[1] = 3'b000;
        tbl[1].drop = 4'd1;

        // Scenario 2: ten clauses into an 8-deep buffer; first is the empty clause.
        tbl[2] = '0;
        tbl[2].nbeats = 8'd10;
        for (int k = 0; k < 8; k++) begin
            tbl[2].pos[k]       = 3'(k);
            tbl[2].neg[k]       = 3'b000;
            tbl[2].words[2*k]   = 3'(k);
            tbl[2].words[2*k+1] = 3'b000;
        end
        tbl[2].pos[8] = 3'b000; tbl[2].neg[8] = 3'b001;
        tbl[2].pos[9] = 3'b000; tbl[2].neg[9] = 3'b010;
        tbl[2].nwords = 8'd16;
        tbl[2].ovf    = 1'b1;

        // Scenario 3: lone tautology carrying last -> empty problem.
        tbl[3] = '0;
        tbl[3].nbeats = 8'd1;
        tbl[3].pos[0] = 3'b011; tbl[3].neg[0] = 3'b011;
        tbl[3].nwords = 8'd0;
        tbl[3].emp    = 1'b1;
        tbl[3].drop   = 4'd1;

        // Back-to-back pair.
        btb_a = '0;
        btb_a.nbeats = 8'd2;
        btb_a.pos[0] = 3'b001; btb_a.neg[0] = 3'b010;
        btb_a.pos[1] = 3'b100; btb_a.neg[1] = 3'b000;
        btb_a.nwords = 8'd4;
        btb_a.words[0] = 3'b001; btb_a.words[1] = 3'b010;
        btb_a.words[2] = 3'b100; btb_a.words[3] = 3'b000;
        btb_b = '0;
        btb_b.nbeats = 8'd2;
        btb_b.pos[0] = 3'b010; btb_b.neg[0] = 3'b001;
        btb_b.pos[1] = 3'b111; btb_b.neg[1] = 3'b000;
        btb_b.nwords = 8'd4;
        btb_b.words[0] = 3'b010; btb_b.words[1] = 3'b001;
        btb_b.words[2] = 3'b111; btb_b.words[3] = 3'b000;

        // Reset state.
        tick();
        tick();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_i", 32'(i), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_empty", 32'(empty_prob), 32'd0);
        chk("rst_drop", 32'(dropped), 32'd0);
        #4;
        reset = 1'b1;
        tick();

        // Table scenarios, run back to back.
        for (int t = 0; t < 4; t++) begin
            feed(tbl[t], $sformatf("s%0d", t));
            drain(tbl[t], $sformatf("s%0d", t));
        end

        // Reset during the third burst word, then reload the same problem.
        feed(tbl[0], "rs");
        tick();
        tick();
        tick();
        chk("rs_i_word2", 32'(i), 32'(3'b101));
        chk("rs_load_word2", 32'(load), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rs_async_load", 32'(load), 32'd0);
        chk("rs_async_i", 32'(i), 32'd0);
        chk("rs_async_ready", 32'(in_ready), 32'd1);
        chk("rs_async_done", 32'(done), 32'd0);
        #1;
        reset = 1'b1;
        feed(tbl[0], "rl");
        drain(tbl[0], "rl");

        // Back-to-back with the second problem's first beat held valid throughout.
        feed(btb_a, "ba");
        in_valid = 1'b1;
        in_pos   = btb_b.pos[0];
        in_neg   = btb_b.neg[0];
        in_last  = 1'b0;
        drain(btb_a, "ba");
        feed(btb_b, "bb");
        drain(btb_b, "bb");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
